// File: rtl/data_mem_responder.sv
// Data-memory responder: word/byte RAM plus cycle-counter and scratch MMIO registers.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the accept cycle; stores commit on the edge entering RESP.
// Backpressure: one access in flight; req is only sampled in IDLE, so a requester simply holds req until accepted.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   req, write_enable,    - request and its attributes, all captured in the accept cycle
//   byte_access, addr,
//   write_data
//   ready, error,         - one-cycle completion pulse, reject flag and load result (both 0 outside ready)
//   read_data
module data_mem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        write_enable,
    input  logic        byte_access,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        ready,
    output logic        error,
    output logic [31:0] read_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int          DEPTH        = 1 << ADDR_WIDTH;
    localparam logic [31:0] SCRATCH_ADDR = MMIO_BASE + 32'd4;
    localparam logic [3:0]  WAIT_LOAD    = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic        we_q;
    logic        byte_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] cnt_snap;
    logic [31:0] cycle_cnt;
    logic [31:0] scratch;
    logic [31:0] ram [DEPTH];

    // The access being served: live inputs during the accept cycle (needed when
    // WAIT_CYCLES=0 completes straight out of IDLE), the latched copy afterwards.
    logic        cur_we;
    logic        cur_byte;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [31:0] cur_cnt;
    logic        accept;
    logic        finish;

    logic                  hit_ram;
    logic                  hit_cnt;
    logic                  hit_scr;
    logic                  bad;
    logic [1:0]            lane;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           ram_word;
    logic [31:0]           load_val;

    always_comb begin
        accept = (state == S_IDLE) && req;
        finish = ((state == S_WAIT) && (wait_cnt == 4'd0)) || (accept && (WAIT_CYCLES == 0));

        if (state == S_IDLE) begin
            cur_we    = write_enable;
            cur_byte  = byte_access;
            cur_addr  = addr;
            cur_wdata = write_data;
            cur_cnt   = cycle_cnt;
        end else begin
            cur_we    = we_q;
            cur_byte  = byte_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_cnt   = cnt_snap;
        end

        hit_ram  = (cur_addr[31:ADDR_WIDTH+2] == '0);
        hit_cnt  = (cur_addr == MMIO_BASE);
        hit_scr  = (cur_addr == SCRATCH_ADDR);
        lane     = cur_addr[1:0];
        word_idx = cur_addr[ADDR_WIDTH+1:2];
        bad      = !(hit_ram || hit_cnt || hit_scr)
                 || (!cur_byte && (lane != 2'd0))
                 || (cur_byte && (hit_cnt || hit_scr));

        ram_word = ram[word_idx];
        if (hit_cnt) begin
            load_val = cur_cnt;
        end else if (hit_scr) begin
            load_val = scratch;
        end else if (cur_byte) begin
            load_val = {24'd0, ram_word[{lane, 3'b000} +: 8]};
        end else begin
            load_val = ram_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            ready     <= 1'b0;
            error     <= 1'b0;
            read_data <= 32'd0;
            cycle_cnt <= 32'd0;
            scratch   <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;

            // Response registers are loaded on the edge entering RESP, so they
            // are nonzero for exactly the RESP cycle.
            ready     <= finish;
            error     <= finish && bad;
            read_data <= (finish && !bad && !cur_we) ? load_val : 32'd0;

            if (finish && cur_we && !bad && hit_scr) begin
                scratch <= cur_wdata;
            end

            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q     <= write_enable;
                        byte_q   <= byte_access;
                        addr_q   <= addr;
                        wdata_q  <= write_data;
                        cnt_snap <= cycle_cnt;
                        wait_cnt <= WAIT_LOAD;
                        state    <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd0) begin
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM has no reset; gating on !reset drops a store whose commit edge
    // coincides with reset.
    always_ff @(posedge clk) begin
        if (!reset && finish && cur_we && !bad && hit_ram) begin
            if (cur_byte) begin
                ram[word_idx][{lane, 3'b000} +: 8] <= cur_wdata[7:0];
            end else begin
                ram[word_idx] <= cur_wdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (WAIT_CYCLES 0, 1, 3) sharing clock and reset.
// Latency and pulse width are measured per access; data checked against a behavioural model.
// Directed cases from the test plan followed by randomized accesses.
module tb_data_mem_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [3];
    logic        we    [3];
    logic        bt    [3];
    logic [31:0] addr  [3];
    logic [31:0] wd    [3];
    logic        rdy   [3];
    logic        err_o [3];
    logic [31:0] rdat  [3];

    int total = 0;
    int bad   = 0;
    int cyc = 0;
    int rst_edge = 0;

    logic [31:0] mem_m [3][1024];
    logic [31:0] scr_m [3];

    always #5 clk = ~clk;

    // Counter model: the DUT counter is zero in the cycle after the last reset edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) rst_edge <= cyc + 1;
    end

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0), .MMIO_BASE(BASE)) u_w0 (
        .clk(clk), .reset(reset), .req(req[0]), .write_enable(we[0]), .byte_access(bt[0]),
        .addr(addr[0]), .write_data(wd[0]), .ready(rdy[0]), .error(err_o[0]), .read_data(rdat[0]));
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1), .MMIO_BASE(BASE)) u_w1 (
        .clk(clk), .reset(reset), .req(req[1]), .write_enable(we[1]), .byte_access(bt[1]),
        .addr(addr[1]), .write_data(wd[1]), .ready(rdy[1]), .error(err_o[1]), .read_data(rdat[1]));
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3), .MMIO_BASE(BASE)) u_w3 (
        .clk(clk), .reset(reset), .req(req[2]), .write_enable(we[2]), .byte_access(bt[2]),
        .addr(addr[2]), .write_data(wd[2]), .ready(rdy[2]), .error(err_o[2]), .read_data(rdat[2]));

    function automatic int wc(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: address map, error rules and data semantics from first principles.
    task automatic model_op(input int k, input bit w, input bit b, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] cnt,
                            output bit e, output logic [31:0] r);
        bit is_ram, is_cnt, is_scr;
        int wi, sh;
        logic [31:0] word;
        is_ram = (a < 32'd4096);
        is_cnt = (a == BASE);
        is_scr = (a == BASE + 32'd4);
        e = !(is_ram || is_cnt || is_scr) || (!b && (a % 4 != 0)) || (b && (is_cnt || is_scr));
        r = 32'd0;
        if (e) return;
        if (is_ram) begin
            wi   = int'(a / 4);
            sh   = 8 * int'(a % 4);
            word = mem_m[k][wi];
            if (w) begin
                if (b) mem_m[k][wi] = (word & ~(32'hFF << sh)) | ({24'd0, d[7:0]} << sh);
                else   mem_m[k][wi] = d;
            end else begin
                r = b ? ((word >> sh) & 32'hFF) : word;
            end
        end else if (is_cnt) begin
            if (!w) r = cnt;
        end else begin
            if (w) scr_m[k] = d;
            else   r = scr_m[k];
        end
    endtask

    // Call just after a negedge with the instance idle; returns after the
    // negedge of the cycle following ready (instance idle again).
    task automatic access(input int k, input bit w, input bit b, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rv, output bit ev);
        int n;
        bit seen, eerr;
        logic [31:0] cnt_t, erd;
        req[k] = 1'b1; we[k] = w; bt[k] = b; addr[k] = a; wd[k] = d;
        cnt_t = 32'(cyc - rst_edge);
        @(posedge clk); #1;
        req[k] = 1'b0;
        n = 1;
        seen = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (rdy[k]) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            n++;
        end
        rv = rdat[k];
        ev = err_o[k];
        if (!seen) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        model_op(k, w, b, a, d, cnt_t, eerr, erd);
        chk("latency", n, 32'(1 + wc(k)));
        chk("error", {31'd0, ev}, {31'd0, eerr});
        chk("read_data", rv, erd);
        @(negedge clk);
        chk("ready_width", {31'd0, rdy[k]}, 32'd0);
        chk("idle_error", {31'd0, err_o[k]}, 32'd0);
        chk("idle_rdata", rdat[k], 32'd0);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 5))
            0, 1:    return 32'($urandom_range(0, 16)) * 32'd4 + 32'($urandom_range(0, 3));
            2:       return 32'hFFC + 32'($urandom_range(0, 3));
            3:       return 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4;
            4:       return BASE + 32'($urandom_range(0, 1)) * 32'd4;
            default: return BASE + 32'($urandom_range(1, 9));
        endcase
    endfunction

    logic [31:0] rv, prior;
    bit ev;

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; bt[k] = 1'b0; addr[k] = 32'd0; wd[k] = 32'd0;
            scr_m[k] = 32'd0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;  // this cycle is counter cycle 0
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", {31'd0, rdy[k]}, 32'd0);
            chk("rst_error", {31'd0, err_o[k]}, 32'd0);
            chk("rst_rdata", rdat[k], 32'd0);
        end
        repeat (5) @(negedge clk);
        access(1, 1'b0, 1'b0, BASE, 32'd0, rv, ev);
        chk("cnt_at_5", rv, 32'd5);

        // Give the touched RAM words known contents.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i <= 17; i++) begin
                access(k, 1'b1, 1'b0, (i == 17) ? 32'hFFC : 32'(i * 4), $urandom, rv, ev);
            end
        end

        // Word round trip, byte lanes, error cases and MMIO on the WAIT_CYCLES=1 instance.
        access(1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rv, ev);
        access(1, 1'b0, 1'b0, 32'h10, 32'd0, rv, ev);
        chk("rt_word", rv, 32'hDEADBEEF);
        access(1, 1'b1, 1'b0, 32'h20, 32'h11223344, rv, ev);
        access(1, 1'b1, 1'b1, 32'h22, 32'h000000AA, rv, ev);
        access(1, 1'b0, 1'b0, 32'h20, 32'd0, rv, ev);
        chk("lane_word", rv, 32'h11AA3344);
        access(1, 1'b0, 1'b1, 32'h23, 32'd0, rv, ev);
        chk("lane_byte", rv, 32'h00000011);
        access(1, 1'b0, 1'b0, 32'h21, 32'd0, rv, ev);
        chk("misalign_err", {31'd0, ev}, 32'd1);
        prior = mem_m[1][0];
        access(1, 1'b1, 1'b0, 32'h0001_0000, 32'h55555555, rv, ev);
        chk("unmapped_err", {31'd0, ev}, 32'd1);
        access(1, 1'b0, 1'b0, 32'h0, 32'd0, rv, ev);
        chk("unmapped_nowrite", rv, prior);
        access(1, 1'b0, 1'b1, BASE, 32'd0, rv, ev);
        chk("mmio_byte_err", {31'd0, ev}, 32'd1);
        access(1, 1'b1, 1'b0, BASE + 32'd4, 32'h12345678, rv, ev);
        access(1, 1'b0, 1'b0, BASE + 32'd4, 32'd0, rv, ev);
        chk("scratch_rt", rv, 32'h12345678);
        access(1, 1'b1, 1'b0, BASE, 32'h0, rv, ev);
        chk("cnt_store_err", {31'd0, ev}, 32'd0);
        access(1, 1'b0, 1'b0, BASE, 32'd0, rv, ev);

        // WAIT_CYCLES=0 with req held: ready on every second cycle.
        req[0] = 1'b1; we[0] = 1'b0; bt[0] = 1'b0; addr[0] = BASE + 32'd4;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk("held_ready", {31'd0, rdy[0]}, 32'(i % 2));
            if (i % 2 == 1) chk("held_rdata", rdat[0], scr_m[0]);
        end
        req[0] = 1'b0;

        // WAIT_CYCLES=3: a store pulse arriving during WAIT must be ignored.
        req[2] = 1'b1; we[2] = 1'b0; bt[2] = 1'b0; addr[2] = BASE + 32'd4;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) req[2] = 1'b0;
            if (i == 2) begin
                req[2] = 1'b1; we[2] = 1'b1; wd[2] = 32'hA5A5_0000 | 32'($urandom_range(1, 255));
            end
            if (i == 3) req[2] = 1'b0;
            chk("pulse_ready", {31'd0, rdy[2]}, {31'd0, (i == 4)});
            if (i == 4) chk("pulse_rdata", rdat[2], scr_m[2]);
        end
        we[2] = 1'b0;
        access(2, 1'b0, 1'b0, BASE + 32'd4, 32'd0, rv, ev);

        // Reset while a store is in WAIT: no ready, no commit, counter restarts.
        prior = mem_m[2][16];
        req[2] = 1'b1; we[2] = 1'b1; bt[2] = 1'b0; addr[2] = 32'h40; wd[2] = 32'hCAFEF00D;
        @(negedge clk);
        req[2] = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) scr_m[k] = 32'd0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_ready", {31'd0, rdy[2]}, 32'd0);
        end
        reset = 1'b0;
        access(2, 1'b0, 1'b0, BASE, 32'd0, rv, ev);
        chk("cnt_restart", rv, 32'd0);
        access(2, 1'b0, 1'b0, 32'h40, 32'd0, rv, ev);
        chk("abort_keep", rv, prior);

        // Randomized mix on all three instances.
        for (int i = 0; i < 200; i++) begin
            access(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   pick_addr(), $urandom, rv, ev);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
